// File: rtl/seq_pkg.sv
// Shared definitions for the sequence transmitter/detector family:
// FSM state encodings and default sizing constants.
package seq_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SHIFT  = 2'd1;
  localparam state_t ST_PARITY = 2'd2;
  localparam state_t ST_GAP    = 2'd3;

  localparam int DEF_PAT_W = 4;
  localparam int DEF_GAP   = 1;
  localparam int DEF_CNT_W = 8;

endpackage

// File: rtl/seq_shift_reg.sv
// Pattern holding register plus MSB-first working shift register.
// cap keeps the accepted pattern so each repetition can be reloaded from it.
module seq_shift_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         reload,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic [W-1:0] sr,
  output logic [W-1:0] cap
);

  always_ff @(posedge clk) begin
    if (rst) begin
      sr  <= '0;
      cap <= '0;
    end else if (load) begin
      sr  <= din;
      cap <= din;
    end else if (reload) begin
      sr <= cap;
    end else if (shift) begin
      sr <= {sr[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: repeats a captured pattern MSB-first with idle gaps.
// Optional even-parity bit per repetition when SEQ_TX_PARITY_EN is defined.
//
// state  | meaning
// IDLE   | waiting for pat_valid handshake
// SHIFT  | pattern bit on dout
// PARITY | parity bit on dout (SEQ_TX_PARITY_EN only)
// GAP    | idle cycles between repetitions
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int GAP   = DEF_GAP,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             pat_valid,
  input  logic [CNT_W-1:0] rep_cnt,
  output logic             pat_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(PAT_W);

  state_t           state, state_n;
  logic [BW-1:0]    bit_cnt;
  logic [3:0]       gap_cnt;
  logic [CNT_W-1:0] rep_left;
  logic [PAT_W-1:0] sr, cap;
  logic             hs, load, reload, shift, end_rep, dout_n;

  assign pat_ready = (state == ST_IDLE) && !rst;
  assign busy      = (state != ST_IDLE);
  assign hs        = pat_valid && pat_ready;

  seq_shift_reg #(.W(PAT_W)) u_sr (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .reload (reload),
    .shift  (shift),
    .din    (pat_in),
    .sr     (sr),
    .cap    (cap)
  );

  always_comb begin
    state_n = state;
    load    = 1'b0;
    reload  = 1'b0;
    shift   = 1'b0;
    end_rep = 1'b0;
    dout_n  = 1'b0;
    case (state)
      ST_IDLE: if (hs) begin
        state_n = ST_SHIFT;
        load    = 1'b1;
      end
      ST_SHIFT: begin
        if (bit_cnt != '0) begin
          shift = 1'b1;
        end else begin
`ifdef SEQ_TX_PARITY_EN
          state_n = ST_PARITY;
`else
          end_rep = 1'b1;
`endif
        end
      end
`ifdef SEQ_TX_PARITY_EN
      ST_PARITY: end_rep = 1'b1;
`endif
      ST_GAP: if (gap_cnt == '0) begin
        state_n = ST_SHIFT;
        reload  = 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase

    // a finished repetition either gaps, restarts back-to-back, or ends the burst
    if (end_rep) begin
      if (rep_left > CNT_W'(1)) begin
        if (GAP > 0) begin
          state_n = ST_GAP;
        end else begin
          state_n = ST_SHIFT;
          reload  = 1'b1;
        end
      end else begin
        state_n = ST_IDLE;
      end
    end

    // dout is registered, so compute the bit that will be visible next cycle
    if (load)        dout_n = pat_in[PAT_W-1];
    else if (reload) dout_n = cap[PAT_W-1];
    else if (shift)  dout_n = sr[PAT_W-2];
`ifdef SEQ_TX_PARITY_EN
    else if (state_n == ST_PARITY) dout_n = ^cap;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      rep_left   <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      dout       <= dout_n;
      dout_valid <= (state_n == ST_SHIFT) || (state_n == ST_PARITY);
      done       <= end_rep && (state_n == ST_IDLE);

      if (load || reload) bit_cnt <= BW'(PAT_W - 1);
      else if (shift)     bit_cnt <= bit_cnt - BW'(1);

      if (load)         rep_left <= (rep_cnt == '0) ? CNT_W'(1) : rep_cnt;
      else if (end_rep) rep_left <= rep_left - CNT_W'(1);

      if (end_rep && (state_n == ST_GAP))       gap_cnt <= 4'(GAP - 1);
      else if (state == ST_GAP && gap_cnt != '0) gap_cnt <= gap_cnt - 4'd1;
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: one instance with GAP=1 and one with GAP=0.
// Expected serial streams are written out by hand, MSB = first cycle after handshake.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] pat_a, pat_b;
  logic       pv_a, pv_b;
  logic [7:0] rc_a, rc_b;
  logic       rdy_a, dout_a, dv_a, busy_a, done_a;
  logic       rdy_b, dout_b, dv_b, busy_b, done_b;

  logic sel;
  logic m_rdy, m_dout, m_dv, m_busy, m_done;

  int n_chk  = 0;
  int n_fail = 0;

`ifdef SEQ_TX_PARITY_EN
  localparam int          L1 = 5;
  localparam logic [31:0] V1 = 32'b11111;
  localparam logic [31:0] D1 = 32'b10010;
  localparam int          L2 = 17;
  localparam logic [31:0] V2 = 32'b11111011111011111;
  localparam logic [31:0] D2 = 32'b10010010010010010;
  localparam int          L5 = 10;
  localparam logic [31:0] V5 = 32'b1111111111;
  localparam logic [31:0] D5 = 32'b1011110111;
  localparam int          L6 = 5;
  localparam logic [31:0] V6 = 32'b11111;
  localparam logic [31:0] D6 = 32'b10111;
`else
  localparam int          L1 = 4;
  localparam logic [31:0] V1 = 32'b1111;
  localparam logic [31:0] D1 = 32'b1001;
  localparam int          L2 = 14;
  localparam logic [31:0] V2 = 32'b11110111101111;
  localparam logic [31:0] D2 = 32'b10010100101001;
  localparam int          L5 = 8;
  localparam logic [31:0] V5 = 32'b11111111;
  localparam logic [31:0] D5 = 32'b10111011;
  localparam int          L6 = 4;
  localparam logic [31:0] V6 = 32'b1111;
  localparam logic [31:0] D6 = 32'b1011;
`endif

  always #5 clk = ~clk;

  seq_pattern_tx #(.PAT_W(4), .GAP(1), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .pat_in(pat_a), .pat_valid(pv_a), .rep_cnt(rc_a),
    .pat_ready(rdy_a), .dout(dout_a), .dout_valid(dv_a), .busy(busy_a), .done(done_a)
  );

  seq_pattern_tx #(.PAT_W(4), .GAP(0), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .pat_in(pat_b), .pat_valid(pv_b), .rep_cnt(rc_b),
    .pat_ready(rdy_b), .dout(dout_b), .dout_valid(dv_b), .busy(busy_b), .done(done_b)
  );

  assign m_rdy  = sel ? rdy_b  : rdy_a;
  assign m_dout = sel ? dout_b : dout_a;
  assign m_dv   = sel ? dv_b   : dv_a;
  assign m_busy = sel ? busy_b : busy_a;
  assign m_done = sel ? done_b : done_a;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic handshake(input logic [3:0] p, input logic [7:0] r, input bit keep);
    if (sel) begin pat_b = p; rc_b = r; pv_b = 1'b1; end
    else     begin pat_a = p; rc_a = r; pv_a = 1'b1; end
    step();
    if (!keep) begin pv_a = 1'b0; pv_b = 1'b0; end
  endtask

  // checks the burst starting in the cycle after the handshake, then the done pulse
  task automatic run(input string tag, input int len, input logic [31:0] ev, input logic [31:0] ed);
    for (int i = 0; i < len; i++) begin
      chk($sformatf("%s_dv_c%0d", tag, i + 1), m_dv, ev[len-1-i]);
      chk($sformatf("%s_dout_c%0d", tag, i + 1), m_dout, ed[len-1-i]);
      chk($sformatf("%s_busy_c%0d", tag, i + 1), m_busy, 1'b1);
      chk($sformatf("%s_done_c%0d", tag, i + 1), m_done, 1'b0);
      chk($sformatf("%s_rdy_c%0d", tag, i + 1), m_rdy, 1'b0);
      step();
    end
    chk({tag, "_done_pulse"}, m_done, 1'b1);
    chk({tag, "_done_busy"}, m_busy, 1'b0);
    chk({tag, "_done_rdy"}, m_rdy, 1'b1);
    chk({tag, "_done_dv"}, m_dv, 1'b0);
    chk({tag, "_done_dout"}, m_dout, 1'b0);
    pv_a = 1'b0;
    pv_b = 1'b0;
    step();
    chk({tag, "_done_clear"}, m_done, 1'b0);
    chk({tag, "_idle_busy"}, m_busy, 1'b0);
  endtask

  initial begin
    sel  = 1'b0;
    rst  = 1'b1;
    pat_a = 4'h0; pat_b = 4'h0;
    pv_a = 1'b0;  pv_b = 1'b0;
    rc_a = 8'd0;  rc_b = 8'd0;
    step();
    step();
    chk("rst_rdy_a", rdy_a, 1'b0);
    chk("rst_rdy_b", rdy_b, 1'b0);
    chk("rst_dv", dv_a, 1'b0);
    chk("rst_busy", busy_a, 1'b0);
    rst = 1'b0;
    #1;
    chk("rst_dout", dout_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("post_rst_rdy", rdy_a, 1'b1);

    // single repetition
    handshake(4'b1001, 8'd1, 1'b0);
    run("t1001x1", L1, V1, D1);

    // three repetitions with one idle cycle between them
    handshake(4'b1001, 8'd3, 1'b0);
    run("t1001x3", L2, V2, D2);

    // rep_cnt 0 behaves as 1; valid held high and pat_in changed while busy
    handshake(4'b1001, 8'd0, 1'b1);
    pat_a = 4'b0110;
    run("t_rep0", L1, V1, D1);

    // different pattern, single repetition
    handshake(4'b1011, 8'd1, 1'b0);
    run("t1011x1", L6, V6, D6);

    // reset during the third bit
    handshake(4'b1001, 8'd1, 1'b0);
    step();
    step();
    chk("rstmid_dv_c3", dv_a, 1'b1);
    chk("rstmid_dout_c3", dout_a, 1'b0);
    rst = 1'b1;
    #1;
    chk("rstmid_rdy_in_rst", rdy_a, 1'b0);
    step();
    chk("rstmid_dv", dv_a, 1'b0);
    chk("rstmid_dout", dout_a, 1'b0);
    chk("rstmid_busy", busy_a, 1'b0);
    chk("rstmid_done", done_a, 1'b0);
    rst = 1'b0;
    #1;
    chk("rstmid_rdy_after", rdy_a, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("rstmid_nodone_%0d", i), done_a, 1'b0);
      chk($sformatf("rstmid_nodv_%0d", i), dv_a, 1'b0);
    end

    // GAP=0 instance, back-to-back repetitions
    sel = 1'b1;
    #1;
    handshake(4'b1011, 8'd2, 1'b0);
    run("t_gap0", L5, V5, D5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
